color_centroid_tracker: RTL and testbench

- Multi-channel successor to the single-target Cr/Cb tracker in the camera path.
- Consumes the per-pixel Cr/Cb stream and its coordinates from camera capture.
- For each of NCH independent colour windows, accumulates the count and the coordinate sums of matching pixels over one frame.
- At frame end, a shared sequential divider computes each channel's centroid; results feed the sprite overlays and the HEX displays.

---
 rtl/color_centroid_tracker.sv | 232 +++++++++++++++++++++++
 tb/tb_color_centroid_tracker.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_centroid_tracker.sv
// Per-channel Cr/Cb window tracker: accumulates matching-pixel count and coordinate sums per frame,
// then runs one shared restoring divider over every channel to produce centroids.
module color_centroid_tracker #(
   parameter int NCH       = 2,
   parameter int X_W       = 10,
   parameter int Y_W       = 10,
   parameter int CNT_W     = 19,
   parameter int MIN_COUNT = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 pix_valid,
   input  logic [X_W-1:0]       pix_x,
   input  logic [Y_W-1:0]       pix_y,
   input  logic [7:0]           pix_cr,
   input  logic [7:0]           pix_cb,
   input  logic                 frame_end,
   input  logic [8*NCH-1:0]     cr_lo,
   input  logic [8*NCH-1:0]     cr_hi,
   input  logic [8*NCH-1:0]     cb_lo,
   input  logic [8*NCH-1:0]     cb_hi,
   output logic [X_W*NCH-1:0]   pos_x,
   output logic [Y_W*NCH-1:0]   pos_y,
   output logic [NCH-1:0]       found,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun
);

   localparam int QW   = (X_W > Y_W) ? X_W : Y_W;
   localparam int SX_W = X_W + CNT_W;
   localparam int SY_W = Y_W + CNT_W;
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int ST_W = $clog2(QW + 1);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV_X, S_DIV_Y, S_STORE, S_DONE} state_t;

   state_t             r_state, w_state_nxt;

   logic [CNT_W-1:0]   r_cnt      [NCH];
   logic [SX_W-1:0]    r_sx       [NCH];
   logic [SY_W-1:0]    r_sy       [NCH];
   logic [CNT_W-1:0]   r_snap_cnt [NCH];
   logic [SX_W-1:0]    r_snap_sx  [NCH];
   logic [SY_W-1:0]    r_snap_sy  [NCH];

   logic [NCH-1:0]     w_match;
   logic [CNT_W-1:0]   w_cnt_nxt  [NCH];
   logic [SX_W-1:0]    w_sx_nxt   [NCH];
   logic [SY_W-1:0]    w_sy_nxt   [NCH];
   logic [SX_W:0]      w_sx_sum   [NCH];
   logic [SY_W:0]      w_sy_sum   [NCH];

   logic [CH_W-1:0]    r_ch;
   logic [ST_W-1:0]    r_step;
   logic [CNT_W-1:0]   r_div;
   logic [CNT_W-1:0]   r_rem;
   logic [QW-1:0]      r_dvd;
   logic               r_skip;
   logic [X_W-1:0]     r_qx;

   logic [CNT_W:0]     w_trial;
   logic               w_ge;
   logic [CNT_W-1:0]   w_rem_nxt;
   logic [QW-1:0]      w_dvd_nxt;
   logic               w_x_last;
   logic               w_y_last;
   logic               w_ch_last;

   logic [X_W*NCH-1:0] r_pos_x;
   logic [Y_W*NCH-1:0] r_pos_y;
   logic [NCH-1:0]     r_found;
   logic               r_busy;
   logic               r_done;
   logic               r_overrun;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         w_match[k]   = pix_valid
                        && (pix_cr >= cr_lo[8*k +: 8]) && (pix_cr <= cr_hi[8*k +: 8])
                        && (pix_cb >= cb_lo[8*k +: 8]) && (pix_cb <= cb_hi[8*k +: 8]);
         w_sx_sum[k]  = {1'b0, r_sx[k]} + (SX_W+1)'(pix_x);
         w_sy_sum[k]  = {1'b0, r_sy[k]} + (SY_W+1)'(pix_y);
         w_cnt_nxt[k] = r_cnt[k];
         w_sx_nxt[k]  = r_sx[k];
         w_sy_nxt[k]  = r_sy[k];
         if (w_match[k]) begin
            w_cnt_nxt[k] = (&r_cnt[k]) ? r_cnt[k] : r_cnt[k] + 1'b1;
            w_sx_nxt[k]  = w_sx_sum[k][SX_W] ? '1 : w_sx_sum[k][SX_W-1:0];
            w_sy_nxt[k]  = w_sy_sum[k][SY_W] ? '1 : w_sy_sum[k][SY_W-1:0];
         end
      end
   end

   // NOTE: these arrays are real flops that must be cleared on reset, so they are reset explicitly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NCH; k++) begin
            r_cnt[k]      <= '0;
            r_sx[k]       <= '0;
            r_sy[k]       <= '0;
            r_snap_cnt[k] <= '0;
            r_snap_sx[k]  <= '0;
            r_snap_sy[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (frame_end) begin
               r_cnt[k] <= '0;
               r_sx[k]  <= '0;
               r_sy[k]  <= '0;
            end else begin
               r_cnt[k] <= w_cnt_nxt[k];
               r_sx[k]  <= w_sx_nxt[k];
               r_sy[k]  <= w_sy_nxt[k];
            end
            // The pixel sharing the frame_end cycle still belongs to the ending frame.
            if (frame_end && (r_state == S_IDLE)) begin
               r_snap_cnt[k] <= w_cnt_nxt[k];
               r_snap_sx[k]  <= w_sx_nxt[k];
               r_snap_sy[k]  <= w_sy_nxt[k];
            end
         end
      end
   end

   // One restoring step: shift the next dividend bit in, subtract if it fits, quotient bit enters at the LSB.
   always_comb begin
      w_trial   = {r_rem, r_dvd[QW-1]};
      w_ge      = (w_trial >= {1'b0, r_div});
      w_rem_nxt = w_ge ? CNT_W'(w_trial - {1'b0, r_div}) : w_trial[CNT_W-1:0];
      w_dvd_nxt = {r_dvd[QW-2:0], w_ge};
      w_x_last  = (r_step == ST_W'(X_W - 1));
      w_y_last  = (r_step == ST_W'(Y_W - 1));
      w_ch_last = (r_ch == CH_W'(NCH - 1));
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (frame_end) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_DIV_X;
         S_DIV_X: if (w_x_last) w_state_nxt = S_DIV_Y;
         S_DIV_Y: if (w_y_last) w_state_nxt = S_STORE;
         S_STORE: w_state_nxt = w_ch_last ? S_DONE : S_LOAD;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ch      <= '0;
         r_step    <= '0;
         r_div     <= '0;
         r_rem     <= '0;
         r_dvd     <= '0;
         r_skip    <= 1'b0;
         r_qx      <= '0;
         r_pos_x   <= '0;
         r_pos_y   <= '0;
         r_found   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_overrun <= frame_end && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               r_ch <= '0;
               if (frame_end) r_busy <= 1'b1;
            end
            S_LOAD: begin
               r_div  <= r_snap_cnt[r_ch];
               r_skip <= (r_snap_cnt[r_ch] == '0) || (r_snap_cnt[r_ch] < MIN_CNT);
               r_rem  <= r_snap_sx[r_ch][SX_W-1:X_W];
               r_dvd  <= QW'(r_snap_sx[r_ch][X_W-1:0]) << (QW - X_W);
               r_step <= '0;
            end
            S_DIV_X: begin
               if (w_x_last) begin
                  r_qx   <= w_dvd_nxt[X_W-1:0];
                  r_rem  <= r_snap_sy[r_ch][SY_W-1:Y_W];
                  r_dvd  <= QW'(r_snap_sy[r_ch][Y_W-1:0]) << (QW - Y_W);
                  r_step <= '0;
               end else begin
                  r_rem  <= w_rem_nxt;
                  r_dvd  <= w_dvd_nxt;
                  r_step <= r_step + 1'b1;
               end
            end
            S_DIV_Y: begin
               r_rem  <= w_rem_nxt;
               r_dvd  <= w_dvd_nxt;
               r_step <= r_step + 1'b1;
            end
            S_STORE: begin
               if (r_skip) begin
                  r_found[r_ch] <= 1'b0;
               end else begin
                  r_pos_x[r_ch*X_W +: X_W] <= r_qx;
                  r_pos_y[r_ch*Y_W +: Y_W] <= r_dvd[Y_W-1:0];
                  r_found[r_ch]            <= 1'b1;
               end
               r_ch <= r_ch + 1'b1;
            end
            S_DONE: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign pos_x   = r_pos_x;
   assign pos_y   = r_pos_y;
   assign found   = r_found;
   assign busy    = r_busy;
   assign done    = r_done;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Scoreboard bench for color_centroid_tracker: two instances (MIN_COUNT 1 and 4) share one pixel stream;
// a behavioural centroid model pushes expected results at frame_end and they are popped on done.
module tb_color_centroid_tracker;

   localparam int NCH   = 2;
   localparam int X_W   = 10;
   localparam int Y_W   = 10;
   localparam int CNT_W = 19;
   localparam int LAT   = NCH * (X_W + Y_W + 2) + 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic pix_valid = 1'b0;
   logic frame_end = 1'b0;
   logic [X_W-1:0] pix_x = '0;
   logic [Y_W-1:0] pix_y = '0;
   logic [7:0] pix_cr = '0;
   logic [7:0] pix_cb = '0;
   logic [7:0] lo_cr [NCH];
   logic [7:0] hi_cr [NCH];
   logic [7:0] lo_cb [NCH];
   logic [7:0] hi_cb [NCH];
   logic [8*NCH-1:0] cr_lo, cr_hi, cb_lo, cb_hi;

   logic [X_W*NCH-1:0] pos_x_a, pos_x_b;
   logic [Y_W*NCH-1:0] pos_y_a, pos_y_b;
   logic [NCH-1:0]     found_a, found_b;
   logic busy_a, busy_b, done_a, done_b, overrun_a, overrun_b;

   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         cr_lo[8*k +: 8] = lo_cr[k];
         cr_hi[8*k +: 8] = hi_cr[k];
         cb_lo[8*k +: 8] = lo_cb[k];
         cb_hi[8*k +: 8] = hi_cb[k];
      end
   end

   color_centroid_tracker #(.NCH(NCH), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_COUNT(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_cr(pix_cr), .pix_cb(pix_cb), .frame_end(frame_end),
      .cr_lo(cr_lo), .cr_hi(cr_hi), .cb_lo(cb_lo), .cb_hi(cb_hi),
      .pos_x(pos_x_a), .pos_y(pos_y_a), .found(found_a),
      .busy(busy_a), .done(done_a), .overrun(overrun_a)
   );

   color_centroid_tracker #(.NCH(NCH), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_COUNT(4)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_cr(pix_cr), .pix_cb(pix_cb), .frame_end(frame_end),
      .cr_lo(cr_lo), .cr_hi(cr_hi), .cb_lo(cb_lo), .cb_hi(cb_hi),
      .pos_x(pos_x_b), .pos_y(pos_y_b), .found(found_b),
      .busy(busy_b), .done(done_b), .overrun(overrun_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [X_W*NCH-1:0] px;
      logic [Y_W*NCH-1:0] py;
      logic [NCH-1:0]     f;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int checks = 0;
   int errors = 0;

   longint             m_cnt [NCH];
   longint             m_sx  [NCH];
   longint             m_sy  [NCH];
   logic [X_W*NCH-1:0] m_px  [2];
   logic [Y_W*NCH-1:0] m_py  [2];
   logic [NCH-1:0]     m_f   [2];

   function automatic longint min_of(input int d);
      return (d == 0) ? 64'd1 : 64'd4;
   endfunction

   function automatic bit model_match(input int k, input int cr, input int cb);
      return (cr >= int'(lo_cr[k])) && (cr <= int'(hi_cr[k])) &&
             (cb >= int'(lo_cb[k])) && (cb <= int'(hi_cb[k]));
   endfunction

   task automatic model_clear_acc();
      for (int k = 0; k < NCH; k++) begin
         m_cnt[k] = 0;
         m_sx[k]  = 0;
         m_sy[k]  = 0;
      end
   endtask

   task automatic model_clear_all();
      model_clear_acc();
      for (int d = 0; d < 2; d++) begin
         m_px[d] = '0;
         m_py[d] = '0;
         m_f[d]  = '0;
      end
      q_a.delete();
      q_b.delete();
   endtask

   task automatic model_acc(input int x, input int y, input int cr, input int cb);
      for (int k = 0; k < NCH; k++) begin
         if (model_match(k, cr, cb)) begin
            m_cnt[k] += 1;
            m_sx[k]  += x;
            m_sy[k]  += y;
         end
      end
   endtask

   task automatic push_expect();
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < NCH; k++) begin
            if (m_cnt[k] != 0 && m_cnt[k] >= min_of(d)) begin
               m_px[d][k*X_W +: X_W] = X_W'(m_sx[k] / m_cnt[k]);
               m_py[d][k*Y_W +: Y_W] = Y_W'(m_sy[k] / m_cnt[k]);
               m_f[d][k] = 1'b1;
            end else begin
               m_f[d][k] = 1'b0;
            end
         end
         e.px = m_px[d];
         e.py = m_py[d];
         e.f  = m_f[d];
         if (d == 0) q_a.push_back(e);
         else        q_b.push_back(e);
      end
      model_clear_acc();
   endtask

   task automatic drive_pixel(input int x, input int y, input int cr, input int cb);
      @(negedge clk);
      pix_valid = 1'b1;
      frame_end = 1'b0;
      pix_x = X_W'(x);
      pix_y = Y_W'(y);
      pix_cr = 8'(cr);
      pix_cb = 8'(cb);
      model_acc(x, y, cr, cb);
   endtask

   task automatic end_frame(input bit with_pix, input int x, input int y, input int cr, input int cb);
      @(negedge clk);
      pix_valid = with_pix;
      frame_end = 1'b1;
      if (with_pix) begin
         pix_x = X_W'(x);
         pix_y = Y_W'(y);
         pix_cr = 8'(cr);
         pix_cb = 8'(cb);
         model_acc(x, y, cr, cb);
      end
      push_expect();
   endtask

   // Waits for done after end_frame; optionally injects a busy frame_end or a reset along the way.
   task automatic wait_done(input int inject_at, input int reset_at);
      int n;
      bit seen;
      exp_t ea, eb;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         pix_valid = 1'b0;
         frame_end = 1'b0;
         if (n == 1) begin
            checks++;
            if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
               errors++;
               $display("FAIL busy_start got a=%b b=%b exp 1", busy_a, busy_b);
            end
         end
         if (n == reset_at) begin
            reset_n = 1'b0;
            #1;
            checks++;
            if ({pos_x_a, pos_y_a, found_a, busy_a, done_a, overrun_a} !== '0) begin
               errors++;
               $display("FAIL reset_mid_a got px=%h py=%h f=%b busy=%b exp all 0", pos_x_a, pos_y_a, found_a, busy_a);
            end
            checks++;
            if ({pos_x_b, pos_y_b, found_b, busy_b, done_b, overrun_b} !== '0) begin
               errors++;
               $display("FAIL reset_mid_b got px=%h py=%h f=%b busy=%b exp all 0", pos_x_b, pos_y_b, found_b, busy_b);
            end
            model_clear_all();
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         if (inject_at > 0 && n == inject_at - 3) begin
            pix_valid = 1'b1;
            pix_x = X_W'(900);
            pix_y = Y_W'(900);
            pix_cr = 8'd110;
            pix_cb = 8'd55;
            model_acc(900, 900, 110, 55);
         end
         if (inject_at > 0 && n == inject_at) begin
            frame_end = 1'b1;
            model_clear_acc();
         end
         if (inject_at > 0 && n == inject_at + 1) begin
            checks++;
            if (overrun_a !== 1'b1 || overrun_b !== 1'b1) begin
               errors++;
               $display("FAIL overrun_pulse got a=%b b=%b exp 1", overrun_a, overrun_b);
            end
         end
         if (inject_at > 0 && n == inject_at + 2) begin
            checks++;
            if (overrun_a !== 1'b0 || overrun_b !== 1'b0) begin
               errors++;
               $display("FAIL overrun_width got a=%b b=%b exp 0", overrun_a, overrun_b);
            end
         end
         if (done_a === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || n != LAT) begin
         errors++;
         $display("FAIL done_latency got %0d (seen=%b) exp %0d", n, seen, LAT);
      end
      if (!seen) return;
      checks++;
      if (done_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("FAIL done_busy got done_b=%b busy_a=%b busy_b=%b exp 1 0 0", done_b, busy_a, busy_b);
      end
      checks++;
      if (q_a.size() == 0 || q_b.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got a=%0d b=%0d exp nonzero", q_a.size(), q_b.size());
      end else begin
         ea = q_a.pop_front();
         eb = q_b.pop_front();
         if (pos_x_a !== ea.px) begin
            errors++;
            $display("FAIL pos_x_a got %h exp %h", pos_x_a, ea.px);
         end
         checks++;
         if (pos_y_a !== ea.py) begin
            errors++;
            $display("FAIL pos_y_a got %h exp %h", pos_y_a, ea.py);
         end
         checks++;
         if (found_a !== ea.f) begin
            errors++;
            $display("FAIL found_a got %b exp %b", found_a, ea.f);
         end
         checks++;
         if (pos_x_b !== eb.px) begin
            errors++;
            $display("FAIL pos_x_b got %h exp %h", pos_x_b, eb.px);
         end
         checks++;
         if (pos_y_b !== eb.py) begin
            errors++;
            $display("FAIL pos_y_b got %h exp %h", pos_y_b, eb.py);
         end
         checks++;
         if (found_b !== eb.f) begin
            errors++;
            $display("FAIL found_b got %b exp %b", found_b, eb.f);
         end
      end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || done_b !== 1'b0) begin
         errors++;
         $display("FAIL done_width got a=%b b=%b exp 0", done_a, done_b);
      end
   endtask

   task automatic test_reset();
      model_clear_all();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pos_x_a, pos_y_a, found_a} !== '0 || {pos_x_b, pos_y_b, found_b} !== '0) begin
         errors++;
         $display("FAIL reset_pos got a=%h/%h/%b b=%h/%h/%b exp 0", pos_x_a, pos_y_a, found_a, pos_x_b, pos_y_b, found_b);
      end
      checks++;
      if ({busy_a, done_a, overrun_a, busy_b, done_b, overrun_b} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 000000", {busy_a, done_a, overrun_a, busy_b, done_b, overrun_b});
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || found_a !== '0) begin
         errors++;
         $display("FAIL post_reset_idle got busy=%b found=%b exp 0 0", busy_a, found_a);
      end
   endtask

   task automatic test_single();
      drive_pixel(100, 50, 110, 55);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(0, 0);
   endtask

   task automatic test_block();
      for (int i = 0; i < 5; i++) drive_pixel(400 + i, 300, 210, 205);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(0, 0);
      for (int y = 20; y <= 21; y++)
         for (int x = 10; x <= 13; x++) drive_pixel(x, y, 105, 52);
      for (int i = 0; i < 3; i++) drive_pixel(300, 200, 215, 219);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(0, 0);
   endtask

   task automatic test_boundary();
      lo_cr[1] = 8'd220;
      hi_cr[1] = 8'd200;
      drive_pixel(0,   7, 100, 55);
      drive_pixel(10,  7, 120, 55);
      drive_pixel(100, 7,  99, 55);
      drive_pixel(200, 7, 121, 55);
      drive_pixel(20,  7, 110, 50);
      drive_pixel(300, 7, 110, 61);
      drive_pixel(500, 9, 210, 210);
      drive_pixel(600, 9, 150, 210);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(0, 0);
      lo_cr[1] = 8'd200;
      hi_cr[1] = 8'd220;
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 4; i++) drive_pixel(50 + 10 * i, 5, 115, 58);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(10, 0);
      for (int i = 0; i < 4; i++) drive_pixel(200 + i, 100, 101, 51);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(0, 0);
   endtask

   task automatic test_same_cycle();
      drive_pixel(10, 10, 110, 55);
      drive_pixel(20, 10, 110, 55);
      drive_pixel(30, 10, 110, 55);
      end_frame(1'b1, 100, 50, 110, 55);
      wait_done(0, 0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) drive_pixel(600 + i, 450, 112, 57);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(0, 15);
      drive_pixel(7, 9, 118, 59);
      for (int i = 0; i < 4; i++) drive_pixel(500 + i, 400, 201, 201);
      end_frame(1'b0, 0, 0, 0, 0);
      wait_done(0, 0);
   endtask

   initial begin
      lo_cr[0] = 8'd100; hi_cr[0] = 8'd120; lo_cb[0] = 8'd50;  hi_cb[0] = 8'd60;
      lo_cr[1] = 8'd200; hi_cr[1] = 8'd220; lo_cb[1] = 8'd200; hi_cb[1] = 8'd220;
      test_reset();
      test_single();
      test_block();
      test_boundary();
      test_overrun();
      test_same_cycle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
